// File: rtl/lse_simd_pkg.sv
// Shared definitions for the SIMD log-domain multiplier datapath:
// lane-mode encoding and the per-mode carry/saturation lane maps.
package lse_simd_pkg;

  typedef enum logic [1:0] {
    SIMD_1X  = 2'b00,
    SIMD_2X  = 2'b01,
    SIMD_4X  = 2'b10,
    SIMD_RSV = 2'b11
  } simd_mode_t;

  localparam int unsigned NUM_BASE_LANES = 4;

  // Bit i set: base lane i takes the carry-out of base lane i-1.
  function automatic logic [NUM_BASE_LANES-1:0] carry_chain_en(input simd_mode_t mode);
    case (mode)
      SIMD_1X: carry_chain_en = 4'b1110;
      SIMD_2X: carry_chain_en = 4'b1010;
      default: carry_chain_en = 4'b0000;
    endcase
  endfunction

  // Bit i set: the carry-out of base lane i is the carry-out of a whole active lane.
  function automatic logic [NUM_BASE_LANES-1:0] carry_report_mask(input simd_mode_t mode);
    case (mode)
      SIMD_1X: carry_report_mask = 4'b1000;
      SIMD_2X: carry_report_mask = 4'b1010;
      SIMD_4X: carry_report_mask = 4'b1111;
      default: carry_report_mask = 4'b0000;
    endcase
  endfunction

  // Expands per-lane overflow flags into the set of base lanes to force to all-ones.
  function automatic logic [NUM_BASE_LANES-1:0] sat_fill_mask(input simd_mode_t mode,
                                                              input logic [NUM_BASE_LANES-1:0] ovf);
    case (mode)
      SIMD_1X: sat_fill_mask = {4{ovf[3]}};
      SIMD_2X: sat_fill_mask = {{2{ovf[3]}}, {2{ovf[1]}}};
      SIMD_4X: sat_fill_mask = ovf;
      default: sat_fill_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lse_lane_adder.sv
// One base-lane adder slice; cin_en gates the carry coming from the lane below.
module lse_lane_adder #(
  parameter int unsigned LANE_W = 6
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              cin,
  input  logic              cin_en,
  output logic [LANE_W-1:0] sum,
  output logic              cout
);

  // Full-width sum with the gated carry-in; the extra bit is the lane carry-out.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (LANE_W+1)'(cin & cin_en);

endmodule

// File: rtl/lse_mult_simd_pipe.sv
// Two-stage pipelined SIMD log-domain multiplier (lane-wise addition) with
// valid/ready on both sides, optional saturation and an overflow event counter.
module lse_mult_simd_pipe
  import lse_simd_pkg::*;
#(
  parameter int unsigned LANE_W = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*LANE_W-1:0]   operand_a,
  input  logic [4*LANE_W-1:0]   operand_b,
  input  logic [1:0]            simd_mode,
  input  logic                  sat_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*LANE_W-1:0]   result,
  output logic [3:0]            lane_ovf,
  output logic                  mode_err,
  output logic [CNT_W-1:0]      ovf_count,
  input  logic                  ovf_clr
);

  localparam int unsigned DATA_W = 4 * LANE_W;

  simd_mode_t                mode_in;
  logic [NUM_BASE_LANES-1:0] chain_en;
  logic [NUM_BASE_LANES-1:0] lane_cin;
  logic [NUM_BASE_LANES-1:0] lane_cout;
  logic [DATA_W-1:0]         raw_sum;

  logic                      s1_valid;
  logic [DATA_W-1:0]         s1_sum;
  logic [NUM_BASE_LANES-1:0] s1_carry;
  simd_mode_t                s1_mode;
  logic                      s1_sat;

  logic                      s1_advance;
  logic                      s2_advance;
  logic                      out_fire;

  logic [NUM_BASE_LANES-1:0] fill;
  logic [DATA_W-1:0]         s2_result;
  logic [NUM_BASE_LANES-1:0] s2_ovf;
  logic                      s2_err;

  assign mode_in  = simd_mode_t'(simd_mode);
  assign chain_en = carry_chain_en(mode_in);
  assign lane_cin = {lane_cout[NUM_BASE_LANES-2:0], 1'b0};

  for (genvar i = 0; i < NUM_BASE_LANES; i++) begin : g_lane
    lse_lane_adder #(.LANE_W(LANE_W)) u_lane (
      .a      (operand_a[i*LANE_W +: LANE_W]),
      .b      (operand_b[i*LANE_W +: LANE_W]),
      .cin    (lane_cin[i]),
      .cin_en (chain_en[i]),
      .sum    (raw_sum[i*LANE_W +: LANE_W]),
      .cout   (lane_cout[i])
    );
  end

  // Each stage moves when empty or when its successor moves, so bubbles collapse.
  assign s2_advance = !out_valid || out_ready;
  assign s1_advance = !s1_valid || s2_advance;
  assign in_ready   = rst_n && (!s1_valid || s1_advance);
  assign out_fire   = out_valid && out_ready;

  // Stage 1: capture raw lane sums and the carry-outs of the active lanes only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_carry <= '0;
      s1_mode  <= SIMD_1X;
      s1_sat   <= 1'b0;
    end else if (s1_advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum   <= raw_sum;
        s1_carry <= lane_cout & carry_report_mask(mode_in);
        s1_mode  <= mode_in;
        s1_sat   <= sat_en;
      end
    end
  end

  // Stage 2 combinational: saturation, overflow flags and reserved-mode squashing.
  always_comb begin
    fill      = '0;
    s2_result = '0;
    s2_ovf    = '0;
    s2_err    = 1'b0;
    if (s1_mode == SIMD_RSV) begin
      s2_err = 1'b1;
    end else begin
      s2_ovf = s1_carry;
      if (s1_sat) fill = sat_fill_mask(s1_mode, s1_carry);
      for (int unsigned i = 0; i < NUM_BASE_LANES; i++) begin
        s2_result[i*LANE_W +: LANE_W] = fill[i] ? {LANE_W{1'b1}} : s1_sum[i*LANE_W +: LANE_W];
      end
    end
  end

  // Stage 2 registers: output payload only changes when the output slot can move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      lane_ovf  <= '0;
      mode_err  <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result   <= s2_result;
        lane_ovf <= s2_ovf;
        mode_err <= s2_err;
      end
    end
  end

  // Count delivered transactions that overflowed any lane; clear wins, count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (ovf_clr) begin
      ovf_count <= '0;
    end else if (out_fire && (lane_ovf != '0) && (ovf_count != '1)) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule
